// File: rtl/ex_muldiv_unit.sv
// ex_muldiv_unit: iterative RV32M multiply/divide unit for the EX stage.
//
// Radix-2 shift-add multiplier and restoring divider that share one 2*DATA_W
// accumulator. Both work on operand magnitudes; the sign is fixed up when the
// result is registered. Divide-by-zero and signed overflow skip iteration.
//
// Ports:
//   clk, reset          clock (rising edge), asynchronous active-high reset
//   start               valid M-extension op in EX this cycle
//   funct3              op select (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU)
//   op_a, op_b          rs1 / rs2 values after forwarding
//   rd_in               destination register of the op in EX
//   flush               kill the in-flight op (taken branch / jump)
//   stall_req           hold PC, IF/ID and ID/EX while the op is pending
//   busy                unit is not idle
//   done                result / rd_out valid this cycle
//   result, rd_out      registered result and its destination; held until next done
module ex_muldiv_unit #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned RF_ADDRESS = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [2:0]            funct3,
  input  logic [DATA_W-1:0]     op_a,
  input  logic [DATA_W-1:0]     op_b,
  input  logic [RF_ADDRESS-1:0] rd_in,
  input  logic                  flush,
  output logic                  stall_req,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_W-1:0]     result,
  output logic [RF_ADDRESS-1:0] rd_out
);

  localparam int unsigned CntW = $clog2(DATA_W) + 1;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e                  state_q, state_d;
  logic [CntW-1:0]         cnt_q, cnt_d;
  logic [2:0]              funct3_q, funct3_d;
  logic [RF_ADDRESS-1:0]   rd_q, rd_d;
  logic                    sign_a_q, sign_a_d;
  logic                    sign_b_q, sign_b_d;
  logic [DATA_W-1:0]       mag_b_q, mag_b_d;
  logic [2*DATA_W-1:0]     acc_q, acc_d;
  logic [DATA_W-1:0]       result_q, result_d;
  logic [RF_ADDRESS-1:0]   rd_out_q, rd_out_d;
  logic                    done_q, done_d;

  // Operand decode for the op presented in IDLE.
  logic              a_signed_in, b_signed_in;
  logic              sign_a_in, sign_b_in;
  logic [DATA_W-1:0] mag_a_in, mag_b_in;
  logic              div_zero, div_ovf, special;
  logic [DATA_W-1:0] special_res;

  always_comb begin
    a_signed_in = funct3[2] ? ~funct3[0] : (funct3[1:0] == 2'b01 || funct3[1:0] == 2'b10);
    b_signed_in = funct3[2] ? ~funct3[0] : (funct3[1:0] == 2'b01);
    sign_a_in   = a_signed_in & op_a[DATA_W-1];
    sign_b_in   = b_signed_in & op_b[DATA_W-1];
    mag_a_in    = sign_a_in ? -op_a : op_a;
    mag_b_in    = sign_b_in ? -op_b : op_b;
    div_zero    = funct3[2] & (op_b == '0);
    div_ovf     = funct3[2] & ~funct3[0] & (op_a == {1'b1, {(DATA_W-1){1'b0}}}) &
                  (op_b == '1);
    special     = div_zero | div_ovf;
    // funct3[1] selects remainder among the divide ops.
    if (div_zero) begin
      special_res = funct3[1] ? op_a : '1;
    end else begin
      special_res = funct3[1] ? '0 : op_a;
    end
  end

  // One iteration of the shared datapath.
  // Multiply: acc = {partial product, remaining multiplier bits}, shift right.
  // Divide:   acc = {partial remainder, remaining dividend / quotient bits}, shift left.
  logic [DATA_W:0]     mul_sum;
  logic [DATA_W:0]     div_rem;
  logic                div_ge;
  logic [DATA_W-1:0]   div_sub;
  logic [2*DATA_W-1:0] acc_step;
  logic [2*DATA_W-1:0] prod_fix;
  logic [DATA_W-1:0]   quo, rem;
  logic [DATA_W-1:0]   final_res;

  always_comb begin
    mul_sum  = {1'b0, acc_q[2*DATA_W-1:DATA_W]} + (acc_q[0] ? {1'b0, mag_b_q} : '0);
    div_rem  = acc_q[2*DATA_W-1:DATA_W-1];
    div_ge   = (div_rem >= {1'b0, mag_b_q});
    // The true difference is below the divisor, so truncating to DATA_W is exact.
    div_sub  = div_rem[DATA_W-1:0] - mag_b_q;
    if (funct3_q[2]) begin
      acc_step = {(div_ge ? div_sub : div_rem[DATA_W-1:0]), acc_q[DATA_W-2:0], div_ge};
    end else begin
      acc_step = {mul_sum, acc_q[DATA_W-1:1]};
    end

    prod_fix = (sign_a_q ^ sign_b_q) ? -acc_step : acc_step;
    quo      = acc_step[DATA_W-1:0];
    rem      = acc_step[2*DATA_W-1:DATA_W];
    case (funct3_q)
      3'b000:                 final_res = prod_fix[DATA_W-1:0];
      3'b001, 3'b010, 3'b011: final_res = prod_fix[2*DATA_W-1:DATA_W];
      3'b100, 3'b101:         final_res = (sign_a_q ^ sign_b_q) ? -quo : quo;
      default:                final_res = sign_a_q ? -rem : rem;
    endcase
  end

  // FSM: state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (start) state_d = special ? StDone : StRun;
      end
      StRun: begin
        if (cnt_q == CntW'(DATA_W - 1)) state_d = StDone;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
    if (flush) state_d = StIdle;
  end

  // FSM: outputs.
  always_comb begin
    busy      = (state_q != StIdle);
    stall_req = ((state_q == StIdle) & start & ~flush) | (state_q == StRun);
    // A flush landing in the DONE cycle must keep the result from retiring.
    done      = done_q & ~flush;
    result    = result_q;
    rd_out    = rd_out_q;
  end

  // Datapath next state.
  always_comb begin
    cnt_d    = cnt_q;
    funct3_d = funct3_q;
    rd_d     = rd_q;
    sign_a_d = sign_a_q;
    sign_b_d = sign_b_q;
    mag_b_d  = mag_b_q;
    acc_d    = acc_q;
    result_d = result_q;
    rd_out_d = rd_out_q;
    done_d   = 1'b0;
    if (!flush) begin
      case (state_q)
        StIdle: begin
          if (start) begin
            funct3_d = funct3;
            rd_d     = rd_in;
            sign_a_d = sign_a_in;
            sign_b_d = sign_b_in;
            mag_b_d  = mag_b_in;
            acc_d    = {{DATA_W{1'b0}}, mag_a_in};
            cnt_d    = '0;
            if (special) begin
              result_d = special_res;
              rd_out_d = rd_in;
              done_d   = 1'b1;
            end
          end
        end
        StRun: begin
          acc_d = acc_step;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CntW'(DATA_W - 1)) begin
            result_d = final_res;
            rd_out_d = rd_q;
            done_d   = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q    <= '0;
      funct3_q <= '0;
      rd_q     <= '0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      mag_b_q  <= '0;
      acc_q    <= '0;
      result_q <= '0;
      rd_out_q <= '0;
      done_q   <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      funct3_q <= funct3_d;
      rd_q     <= rd_d;
      sign_a_q <= sign_a_d;
      sign_b_q <= sign_b_d;
      mag_b_q  <= mag_b_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      rd_out_q <= rd_out_d;
      done_q   <= done_d;
    end
  end

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Directed, table-driven bench for ex_muldiv_unit at DATA_W=32.
module tb_ex_muldiv_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  funct3;
  logic [31:0] op_a, op_b;
  logic [4:0]  rd_in;
  logic        flush;
  logic        stall_req, busy, done;
  logic [31:0] result;
  logic [4:0]  rd_out;

  int n_total = 0;
  int n_pass  = 0;
  int cyc_ctr = 0;

  ex_muldiv_unit #(.DATA_W(32), .RF_ADDRESS(5)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .funct3    (funct3),
    .op_a      (op_a),
    .op_b      (op_b),
    .rd_in     (rd_in),
    .flush     (flush),
    .stall_req (stall_req),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .rd_out    (rd_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc_ctr <= cyc_ctr + 1;

  typedef struct {
    string       name;
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic [31:0] exp_res;
    int          exp_cyc;
    int          exp_stall;
  } vec_t;

  vec_t vecs[18];

  function automatic vec_t mk(input string name, input logic [2:0] f3, input logic [31:0] a,
                              input logic [31:0] b, input logic [4:0] rd,
                              input logic [31:0] exp_res, input int exp_cyc);
    vec_t v;
    v.name      = name;
    v.f3        = f3;
    v.a         = a;
    v.b         = b;
    v.rd        = rd;
    v.exp_res   = exp_res;
    v.exp_cyc   = exp_cyc;
    v.exp_stall = exp_cyc;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents one op in the current cycle (start held while stalled, like the
  // pipeline would), waits for done and checks latency, stall length and outputs.
  task automatic run_op(input vec_t v, output int done_at);
    int cyc = 0;
    int stall_cnt = 0;
    bit got = 0;
    start  = 1'b1;
    funct3 = v.f3;
    op_a   = v.a;
    op_b   = v.b;
    rd_in  = v.rd;
    #1;
    while (!got && cyc < 100) begin
      if (stall_req) stall_cnt++;
      if (done) got = 1;
      else begin
        step();
        cyc++;
      end
    end
    start   = 1'b0;
    done_at = cyc_ctr;
    check({v.name, " done seen"}, 32'(got), 32'd1);
    check({v.name, " latency"}, 32'(cyc), 32'(v.exp_cyc));
    check({v.name, " stall cycles"}, 32'(stall_cnt), 32'(v.exp_stall));
    check({v.name, " result"}, result, v.exp_res);
    check({v.name, " rd_out"}, 32'(rd_out), 32'(v.rd));
  endtask

  int   t0, t_done, t_dummy;
  bit   done_seen;
  vec_t v;

  initial begin
    vecs[0]  = mk("MUL 7*-3",        3'b000, 32'd7,        32'hFFFFFFFD, 5'd1,  32'hFFFFFFEB, 33);
    vecs[1]  = mk("MULH min*min",    3'b001, 32'h80000000, 32'h80000000, 5'd2,  32'h40000000, 33);
    vecs[2]  = mk("MULHU max*max",   3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd3,  32'hFFFFFFFE, 33);
    vecs[3]  = mk("MULHSU -1*2",     3'b010, 32'hFFFFFFFF, 32'd2,        5'd4,  32'hFFFFFFFF, 33);
    vecs[4]  = mk("MULH -1*-1",      3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd5,  32'h00000000, 33);
    vecs[5]  = mk("MULH -1*1",       3'b001, 32'hFFFFFFFF, 32'd1,        5'd6,  32'hFFFFFFFF, 33);
    vecs[6]  = mk("DIV -7/2",        3'b100, 32'hFFFFFFF9, 32'd2,        5'd7,  32'hFFFFFFFD, 33);
    vecs[7]  = mk("REM -7/2",        3'b110, 32'hFFFFFFF9, 32'd2,        5'd8,  32'hFFFFFFFF, 33);
    vecs[8]  = mk("DIVU -7/2",       3'b101, 32'hFFFFFFF9, 32'd2,        5'd9,  32'h7FFFFFFC, 33);
    vecs[9]  = mk("DIV 100/-7",      3'b100, 32'd100,      32'hFFFFFFF9, 5'd10, 32'hFFFFFFF2, 33);
    vecs[10] = mk("REM 100/-7",      3'b110, 32'd100,      32'hFFFFFFF9, 5'd11, 32'd2,        33);
    vecs[11] = mk("REMU 100/7",      3'b111, 32'd100,      32'd7,        5'd12, 32'd2,        33);
    vecs[12] = mk("DIV min/2",       3'b100, 32'h80000000, 32'd2,        5'd13, 32'hC0000000, 33);
    vecs[13] = mk("DIVU 5/0",        3'b101, 32'd5,        32'd0,        5'd14, 32'hFFFFFFFF, 1);
    vecs[14] = mk("REM 5/0",         3'b110, 32'd5,        32'd0,        5'd15, 32'd5,        1);
    vecs[15] = mk("DIV min/-1",      3'b100, 32'h80000000, 32'hFFFFFFFF, 5'd16, 32'h80000000, 1);
    vecs[16] = mk("REM min/-1",      3'b110, 32'h80000000, 32'hFFFFFFFF, 5'd17, 32'd0,        1);
    vecs[17] = mk("DIV 0/0",         3'b100, 32'd0,        32'd0,        5'd18, 32'hFFFFFFFF, 1);

    reset  = 1'b1;
    start  = 1'b0;
    flush  = 1'b0;
    funct3 = '0;
    op_a   = '0;
    op_b   = '0;
    rd_in  = '0;
    #1;
    check("reset stall_req", 32'(stall_req), 32'd0);
    check("reset busy",      32'(busy),      32'd0);
    check("reset done",      32'(done),      32'd0);
    check("reset result",    result,         32'd0);
    check("reset rd_out",    32'(rd_out),    32'd0);
    #11;
    reset = 1'b0;
    step();

    // Table: each op followed by one IDLE cycle where done must be low.
    for (int i = 0; i < 18; i++) begin
      run_op(vecs[i], t_dummy);
      step();
      check({vecs[i].name, " done low after"}, 32'(done), 32'd0);
      check({vecs[i].name, " result held"}, result, vecs[i].exp_res);
    end

    // Back-to-back: second start in the IDLE cycle right after DONE.
    t0 = cyc_ctr;
    run_op(mk("b2b MUL 2*3", 3'b000, 32'd2, 32'd3, 5'd20, 32'd6, 33), t_done);
    check("b2b first done cycle", 32'(t_done - t0), 32'd33);
    step();
    run_op(mk("b2b MULHU", 3'b011, 32'h00010000, 32'h00010000, 5'd21, 32'd1, 33), t_done);
    check("b2b second done cycle", 32'(t_done - t0), 32'd67);
    step();

    // Flush at cycle 10 of a DIV, new MUL in cycle 11.
    t0        = cyc_ctr;
    done_seen = 0;
    start     = 1'b1;
    funct3    = 3'b100;
    op_a      = 32'd100;
    op_b      = 32'd7;
    rd_in     = 5'd22;
    for (int c = 0; c < 10; c++) begin
      #1;
      if (done) done_seen = 1;
      step();
    end
    flush = 1'b1;
    #1;
    if (done) done_seen = 1;
    step();
    flush = 1'b0;
    start = 1'b0;
    #1;
    check("flush cycle index", 32'(cyc_ctr - t0), 32'd11);
    check("flush busy",        32'(busy),        32'd0);
    check("flush stall_req",   32'(stall_req),   32'd0);
    check("flush done never",  32'(done_seen | done), 32'd0);
    check("flush result kept", result,           32'd1);
    run_op(mk("post-flush MUL 3*4", 3'b000, 32'd3, 32'd4, 5'd23, 32'd12, 33), t_done);
    check("post-flush done cycle", 32'(t_done - t0), 32'd44);
    step();

    // Flush landing in the DONE cycle suppresses done.
    start  = 1'b1;
    funct3 = 3'b101;
    op_a   = 32'd5;
    op_b   = 32'd0;
    rd_in  = 5'd24;
    step();
    flush = 1'b1;
    #1;
    check("flush in DONE done", 32'(done), 32'd0);
    step();
    flush = 1'b0;
    start = 1'b0;
    #1;
    check("after DONE flush busy", 32'(busy), 32'd0);
    step();

    // Asynchronous reset in the middle of RUN.
    start  = 1'b1;
    funct3 = 3'b000;
    op_a   = 32'd7;
    op_b   = 32'd9;
    rd_in  = 5'd25;
    for (int c = 0; c < 5; c++) step();
    check("pre-reset busy", 32'(busy), 32'd1);
    #3;
    reset = 1'b1;
    start = 1'b0;
    #1;
    check("mid reset stall_req", 32'(stall_req), 32'd0);
    check("mid reset busy",      32'(busy),      32'd0);
    check("mid reset done",      32'(done),      32'd0);
    check("mid reset result",    result,         32'd0);
    check("mid reset rd_out",    32'(rd_out),    32'd0);
    @(negedge clk);
    reset = 1'b0;
    step();
    run_op(mk("post-reset MUL 3*5", 3'b000, 32'd3, 32'd5, 5'd26, 32'd15, 33), t_dummy);
    step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
